// File: rtl/seq_mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding,
// default operand width and the iteration-counter width derivation.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned SEQ_MUL_WIDTH = 8;

    function automatic int unsigned seq_mul_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mul_cu.sv
// Control FSM for seq_mul: sequences load, add/shift iterations and DONE.
// SEQ_MUL_EARLY_EXIT_EN: leave ITER once the unconsumed multiplier bits are zero.
module seq_mul_cu
    import seq_mul_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic b_lsb,
    input  logic cnt_zero,
    input  logic op_zero,
    input  logic rem_zero,
    output logic ld,
    output logic add_en,
    output logic shift,
    output logic cnt_en,
    output logic fin_zero,
    output logic fin_iter,
    output logic busy,
    output logic valid
);

    state_e state_q, state_d;
    logic   busy_q, busy_d;
    logic   valid_q, valid_d;
    logic   last_step;

    always_comb begin
`ifdef SEQ_MUL_EARLY_EXIT_EN
        last_step = cnt_zero | rem_zero;
`else
        // rem_zero is always set on the final count, so this is the full-count exit
        last_step = cnt_zero & rem_zero;
`endif
        ld       = (state_q == IDLE) && start;
        add_en   = (state_q == ITER) && b_lsb;
        shift    = (state_q == ITER);
        cnt_en   = (state_q == ITER);
        fin_zero = (state_q == CHECK) && op_zero;
        fin_iter = (state_q == ITER) && last_step;

        state_d = state_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CHECK;
                    busy_d  = 1'b1;
                end
            end
            CHECK: begin
                if (op_zero) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                if (last_step) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-and-add unsigned multiplier datapath with start/busy/valid handshake.
// Optional SEQ_MUL_EARLY_EXIT_EN (in seq_mul_cu) ends iteration once the multiplier is exhausted.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_MUL_WIDTH,
    parameter int unsigned CNT_W = seq_mul_cnt_w(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 valid,
    output logic                 zero,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               zero_q, zero_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_s, b_s;
    logic [CNT_W-1:0]   rem_cnt;
    logic [2*WIDTH-1:0] full_s;

    logic ld, add_en, shift, cnt_en, fin_zero, fin_iter;
    logic b_lsb, cnt_zero, op_zero, rem_zero;

    seq_mul_cu u_cu (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .b_lsb    (b_lsb),
        .cnt_zero (cnt_zero),
        .op_zero  (op_zero),
        .rem_zero (rem_zero),
        .ld       (ld),
        .add_en   (add_en),
        .shift    (shift),
        .cnt_en   (cnt_en),
        .fin_zero (fin_zero),
        .fin_iter (fin_iter),
        .busy     (busy),
        .valid    (valid)
    );

    always_comb begin
        // One step: optional add into the carry-extended accumulator, then shift {carry,ACC,B} right
        sum     = {1'b0, acc_q} + (add_en ? {1'b0, a_q} : '0);
        acc_s   = sum[WIDTH:1];
        b_s     = {sum[0], b_q[WIDTH-1:1]};
        rem_cnt = cnt_q - CNT_W'(1);
        full_s  = {acc_s, b_s};

        b_lsb    = b_q[0];
        cnt_zero = (cnt_q == CNT_W'(1));
        op_zero  = (a_q == '0) || (b_q == '0);
        // Low rem_cnt bits of B are the multiplier bits still to be consumed
        rem_zero = ((b_s & ~(ONES << rem_cnt)) == '0);

        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        zero_d    = zero_q;

        if (ld) begin
            a_d    = a_in;
            b_d    = b_in;
            acc_d  = '0;
            cnt_d  = CNT_W'(WIDTH);
            zero_d = 1'b0;
        end
        if (shift) begin
            acc_d = acc_s;
            b_d   = b_s;
        end
        if (cnt_en) begin
            cnt_d = rem_cnt;
        end
        if (fin_zero) begin
            product_d = '0;
            zero_d    = 1'b1;
        end
        if (fin_iter) begin
            product_d = full_s >> rem_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            zero_q    <= zero_d;
        end
    end

    assign product = product_q;
    assign zero    = zero_q;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul (WIDTH=8): cycle-level reference model plus
// directed literal checks; honours SEQ_MUL_EARLY_EXIT_EN for expected latency.
module tb_seq_mul;

    localparam int unsigned W = 8;

`ifdef SEQ_MUL_EARLY_EXIT_EN
    localparam int unsigned L_13_11  = 6;
    localparam int unsigned L_FF_FF  = 10;
    localparam int unsigned L_1_FF   = 10;
    localparam int unsigned L_200_3  = 4;
    localparam int unsigned L_6_7    = 5;
`else
    localparam int unsigned L_13_11  = 10;
    localparam int unsigned L_FF_FF  = 10;
    localparam int unsigned L_1_FF   = 10;
    localparam int unsigned L_200_3  = 10;
    localparam int unsigned L_6_7    = 10;
`endif

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           busy;
    logic           valid;
    logic           zero;
    logic [2*W-1:0] product;

    int unsigned vectors = 0;
    int unsigned errs    = 0;

    seq_mul #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .valid   (valid),
        .zero    (zero),
        .product (product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: number of cycles from the accepting edge to the valid cycle
    function automatic int unsigned op_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned hb;
        if (a == '0 || b == '0) return 2;
`ifdef SEQ_MUL_EARLY_EXIT_EN
        hb = 0;
        for (int i = 0; i < int'(W); i++) if (b[i]) hb = i;
        return 2 + hb + 1;
`else
        hb = W;
        return 2 + hb;
`endif
    endfunction

    // Model: m_phase counts cycles since the accepting edge (0 = idle)
    bit             model_ok = 1'b0;
    int unsigned    m_phase  = 0;
    int unsigned    m_lat    = 0;
    logic [2*W-1:0] m_prod   = '0;
    logic           m_zero   = 1'b0;
    logic [2*W-1:0] p_prod   = '0;
    logic           p_zero   = 1'b0;

    always @(posedge clk) begin
        model_ok <= 1'b1;
        if (rst) begin
            m_phase <= 0;
            m_prod  <= '0;
            m_zero  <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_lat   <= op_lat(a_in, b_in);
                p_prod  <= (2*W)'(a_in) * (2*W)'(b_in);
                p_zero  <= (a_in == '0) || (b_in == '0);
                m_zero  <= 1'b0;
            end
        end else if (m_phase == m_lat) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
            if (m_phase + 1 == m_lat) begin
                m_prod <= p_prod;
                m_zero <= p_zero;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model busy",    32'(busy),    32'(m_phase != 0));
            chk("model valid",   32'(valid),   32'(m_phase != 0 && m_phase == m_lat));
            chk("model zero",    32'(zero),    32'(m_zero));
            chk("model product", 32'(product), 32'(m_prod));
        end
    end

    // Starts an op from IDLE at a negedge; returns at the first IDLE cycle after valid
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int unsigned lat_exp, input logic [2*W-1:0] p_exp,
                         input logic z_exp, input string name);
        int unsigned c;
        bit seen;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        chk({name, " busy@1"}, 32'(busy), 32'(1));
        c    = 1;
        seen = 1'b0;
        while (c < 40 && !seen) begin
            if (valid) seen = 1'b1;
            else begin
                @(negedge clk);
                c++;
            end
        end
        chk({name, " valid cycle"}, seen ? c : 32'hFFFF_FFFF, lat_exp);
        chk({name, " product"}, 32'(product), 32'(p_exp));
        chk({name, " zero"}, 32'(zero), 32'(z_exp));
        @(negedge clk);
        chk({name, " idle after"}, 32'(busy), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nv, vc;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        @(negedge clk);
        chk("reset busy",    32'(busy),    32'(0));
        chk("reset valid",   32'(valid),   32'(0));
        chk("reset zero",    32'(zero),    32'(0));
        chk("reset product", 32'(product), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        do_op(8'd13,  8'd11,  L_13_11, 16'd143,   1'b0, "13x11");
        do_op(8'd255, 8'd255, L_FF_FF, 16'd65025, 1'b0, "255x255");
        do_op(8'd1,   8'd255, L_1_FF,  16'd255,   1'b0, "1x255");
        do_op(8'd0,   8'd200, 2,       16'd0,     1'b1, "0x200");
        do_op(8'd7,   8'd0,   2,       16'd0,     1'b1, "7x0");
        do_op(8'd200, 8'd3,   L_200_3, 16'd600,   1'b0, "200x3");

        // Starts during CHECK/ITER and in DONE are ignored
        start = 1'b1;
        a_in  = 8'd13;
        b_in  = 8'd11;
        nv = 0;
        vc = 0;
        for (int unsigned c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (valid) begin
                nv++;
                vc = c;
            end
            start = (c == 3 || c == L_13_11);
            a_in  = W'($urandom);
            b_in  = W'($urandom);
        end
        start = 1'b0;
        chk("pulse valid count", nv, 1);
        chk("pulse valid cycle", vc, L_13_11);
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold product", 32'(product), 32'd143);
        end

        // Reset during 200x100, then a normal op
        start = 1'b1;
        a_in  = 8'd200;
        b_in  = 8'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid-rst busy",    32'(busy),    32'(0));
        chk("mid-rst valid",   32'(valid),   32'(0));
        chk("mid-rst product", 32'(product), 32'(0));
        do_op(8'd6, 8'd7, L_6_7, 16'd42, 1'b0, "6x7");

        // Random traffic checked cycle by cycle against the model
        for (int unsigned i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            a_in  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            b_in  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rst   = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
